// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 4-bit Galois LFSR stream (x^4+x+1).
// Acquires lock through SEARCH/VERIFY, then flywheels and counts deviations.
module lfsr_seq_checker #(
  parameter int ERR_CNT_WIDTH = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     clear_in,
  input  logic                     valid_in,
  input  logic [3:0]               data_in,
  output logic                     locked_out,
  output logic                     error_out,
  output logic [ERR_CNT_WIDTH-1:0] err_count_out
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]               LOCK_CNT_L   = 4'(LOCK_COUNT);
  localparam logic [3:0]               UNLOCK_CNT_L = 4'(UNLOCK_ERRORS);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX      = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE      = ERR_CNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [3:0]               expected_q, expected_d;
  logic [3:0]               match_cnt_q, match_cnt_d;
  logic [3:0]               miss_cnt_q, miss_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     error_q, error_d;
  logic                     locked_q;
  logic [3:0]               match_inc;
  logic [3:0]               miss_inc;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2], q[1], q[0] ^ q[3], q[3]};
  endfunction

  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    error_d     = 1'b0;
    if (clear_in) begin
      state_d     = SEARCH;
      expected_d  = 4'd0;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 4'd0;
      err_cnt_d   = '0;
    end else if (valid_in) begin
      case (state_q)
        SEARCH: begin
          // Zero is the LFSR lockup value and can never seed the sequence.
          if (data_in != 4'd0) begin
            expected_d  = lfsr_next(data_in);
            match_cnt_d = 4'd1;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == expected_q) begin
            expected_d  = lfsr_next(data_in);
            match_cnt_d = match_inc;
            if (match_inc == LOCK_CNT_L) begin
              state_d    = LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else if (data_in != 4'd0) begin
            expected_d  = lfsr_next(data_in);
            match_cnt_d = 4'd1;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: expected advances from itself, never from received data.
          expected_d = lfsr_next(expected_q);
          if (data_in == expected_q) begin
            miss_cnt_d = 4'd0;
          end else begin
            error_d    = 1'b1;
            miss_cnt_d = miss_inc;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end
            if (miss_inc == UNLOCK_CNT_L) begin
              state_d = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= SEARCH;
      expected_q  <= 4'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_cnt_q   <= '0;
      error_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      error_q     <= error_d;
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign locked_out    = locked_q;
  assign error_out     = error_q;
  assign err_count_out = err_cnt_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: sequence-table reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_lfsr_seq_checker;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 3;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  data_in  = 4'd0;
  logic        locked_a, error_a;
  logic [15:0] err_a;
  logic        locked_b, error_b;
  logic [1:0]  err_b;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_seq_checker dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clear_in(clear_in),
    .valid_in(valid_in), .data_in(data_in),
    .locked_out(locked_a), .error_out(error_a), .err_count_out(err_a)
  );

  lfsr_seq_checker #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clear_in(clear_in),
    .valid_in(valid_in), .data_in(data_in),
    .locked_out(locked_b), .error_out(error_b), .err_count_out(err_b)
  );

  always #5 clk_in = ~clk_in;

  // The period-15 sequence written out; successor is simply the next entry.
  int seq [15] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9};

  function automatic int nxt(input int w);
    for (int i = 0; i < 15; i++)
      if (seq[i] == w) return seq[(i + 1) % 15];
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=searching, 1=verifying, 2=locked.
  int m_mode = 0, m_exp = 0, m_match = 0, m_miss = 0, m_err = 0;
  int m_locked = 0, m_pulse = 0;

  initial forever begin
    @(posedge clk_in or negedge rst_n_in);
    if (!rst_n_in) begin
      m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 0;
    end else if (clear_in) begin
      m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (valid_in) begin
        case (m_mode)
          0: if (data_in != 0) begin
               m_exp = nxt(data_in); m_match = 1; m_mode = 1;
             end
          1: if (int'(data_in) == m_exp) begin
               m_exp = nxt(data_in); m_match++;
               if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
             end else if (data_in != 0) begin
               m_exp = nxt(data_in); m_match = 1;
             end else m_mode = 0;
          default: begin
            if (int'(data_in) == m_exp) m_miss = 0;
            else begin
              m_pulse = 1; m_err++; m_miss++;
              if (m_miss == UNLOCK_N) m_mode = 0;
            end
            m_exp = nxt(m_exp);
          end
        endcase
      end
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  end

  initial forever begin
    @(negedge clk_in);
    check("locked", locked_a, m_locked);
    check("error", error_a, m_pulse);
    check("err_count", err_a, (m_err > 65535) ? 65535 : m_err);
    check("sat_locked", locked_b, m_locked);
    check("sat_error", error_b, m_pulse);
    check("sat_err_count", err_b, (m_err > 3) ? 3 : m_err);
  end

  task automatic send(input int w);
    valid_in = 1'b1;
    data_in  = 4'(w);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    @(posedge clk_in); #1;
    clear_in = 1'b0;
  endtask

  task automatic lock_seq();
    send(1); send(2); send(4); send(8);
  endtask

  int src;

  initial begin
    check("model_f1", nxt(1), 2);
    check("model_f8", nxt(8), 3);
    check("model_f9", nxt(9), 1);

    idle(2);
    check("reset_locked", locked_a, 0);
    check("reset_err", err_a, 0);
    check("reset_error", error_a, 0);
    rst_n_in = 1'b1;
    idle(1);

    // Lock acquisition
    send(1); send(2); send(4);
    check("pre_lock", locked_a, 0);
    send(8);
    check("lock_rise", locked_a, 1);
    check("lock_err0", err_a, 0);

    // Single injected error; flywheel keeps B and 5 matching
    send(3); send(6); send(0);
    $display("single error: error_out=%0d err_count=%0d", error_a, err_a);
    check("inj_pulse", error_a, 1);
    check("inj_count", err_a, 1);
    send(11);
    check("inj_nopulse", error_a, 0);
    send(5);
    check("inj_locked", locked_a, 1);
    check("inj_count_hold", err_a, 1);

    // Loss of lock and relock
    do_clear();
    lock_seq();
    send(15); send(15);
    check("lol_still_locked", locked_a, 1);
    send(15);
    check("lol_fall", locked_a, 0);
    check("lol_count", err_a, 3);
    send(5); send(10); send(7); send(14);
    $display("relock: locked=%0d err_count=%0d", locked_a, err_a);
    check("relock", locked_a, 1);
    check("relock_count", err_a, 3);

    // Search robustness
    do_clear();
    send(0); send(0); send(1); send(2); send(7); send(14); send(15);
    check("search_not_yet", locked_a, 0);
    send(13);
    check("search_lock", locked_a, 1);
    check("search_err0", err_a, 0);

    // Valid gaps and saturation
    do_clear();
    foreach (seq[i]) if (i < 4) begin
      send(seq[i]);
      idle($urandom_range(1, 3));
    end
    check("gap_lock", locked_a, 1);
    begin
      int pat [10] = '{0, 6, 0, 11, 0, 10, 0, 14, 0, 13};
      foreach (pat[i]) begin
        send(pat[i]);
        idle($urandom_range(0, 2));
      end
    end
    $display("saturation: wide=%0d narrow=%0d locked=%0d", err_a, err_b, locked_b);
    check("sat_narrow", err_b, 3);
    check("sat_wide", err_a, 5);
    check("sat_locked_lit", locked_b, 1);

    // Asynchronous reset mid-lock
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_locked", locked_a, 0);
    check("arst_err", err_a, 0);
    check("arst_sat_err", err_b, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    idle(1);

    // Clear discards a coincident mismatching word
    lock_seq();
    clear_in = 1'b1; valid_in = 1'b1; data_in = 4'd15;
    @(posedge clk_in); #1;
    clear_in = 1'b0; valid_in = 1'b0;
    check("clr_error", error_a, 0);
    check("clr_err", err_a, 0);
    check("clr_locked", locked_a, 0);

    // Random traffic: mostly in-sequence words, with corruptions and clears
    src = $urandom_range(0, 14);
    for (int c = 0; c < 3000; c++) begin
      clear_in = ($urandom_range(0, 299) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      if (valid_in) begin
        if ($urandom_range(0, 9) == 0) data_in = 4'($urandom_range(0, 15));
        else data_in = 4'(seq[src]);
        if ($urandom_range(0, 49) == 0) src = $urandom_range(0, 14);
        else src = (src + 1) % 15;
      end
      @(posedge clk_in); #1;
    end
    clear_in = 1'b0; valid_in = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Receives the 4-bit pseudo-random word stream produced by the team's 4-bit Galois LFSR (polynomial x^4+x+1, period 15), self-synchronises to it, and counts words that deviate from the sequence. It sits downstream of the LFSR, at the far end of a camera-path link or FIFO, as a built-in self-test checker. Lock status and a saturating error count go to the debug/status logic.

## Interface
- ERR_CNT_WIDTH, 16: width of the saturating error counter.
- LOCK_COUNT, 4: consecutive in-sequence valid words needed to lock, including the seeding word (legal range 2..15).
- UNLOCK_ERRORS, 3: consecutive mismatches while locked that force loss of lock (legal range 1..15).
- clk_in  input  1  single clock; all logic is on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous clear of state and counters; it has priority over valid_in.
- valid_in  input  1  data_in carries a word this cycle.
- data_in  input  4  received LFSR word.
- locked_out  output  1  checker is locked to the sequence.
- error_out  output  1  one-cycle pulse for each mismatching word while locked.
- err_count_out  output  ERR_CNT_WIDTH  saturating count of mismatches while locked.

## Operation
- Next-state function f(q): f[0]=q[3], f[1]=q[0]^q[3], f[2]=q[1], f[3]=q[2]. Sequence from 1: 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1.
- Internal registers: state, expected[3:0], match_cnt[3:0], miss_cnt[3:0].
- SEARCH (reset state):
  - On a valid word w==0 (illegal lockup value): stay in SEARCH.
  - On a valid word w!=0: expected<=f(w), match_cnt<=1, go to VERIFY.
- VERIFY:
  - On a valid word w==expected: expected<=f(w), match_cnt++. If the incremented count equals LOCK_COUNT, go to LOCKED with miss_cnt<=0.
  - On a mismatch with w!=0: reseed with expected<=f(w), match_cnt<=1.
  - On a mismatch with w==0: go to SEARCH.
  - Errors are never counted in VERIFY.
- LOCKED:
  - On every valid word, expected<=f(expected). This is flywheel behaviour: the checker never reseeds from data while locked.
  - On a match: miss_cnt<=0.
  - On a mismatch: pulse error_out, increment err_count_out (saturating), miss_cnt++.
  - If the incremented miss_cnt equals UNLOCK_ERRORS, go to SEARCH. That word still counts as an error.
- Cycles with valid_in=0 change nothing: no state change, no aging of expected, no error_out.
- err_count_out saturates at 2^ERR_CNT_WIDTH-1. It survives loss of lock and relock, and is cleared only by reset or clear_in.
- clear_in=1: state<=SEARCH, all counters <=0, error_out<=0. A word valid in the same cycle is discarded.

## Timing
- All outputs are registers and change on the edge that samples the causing word; they are visible in the following cycle. Latency from data to status is 1 cycle.
- locked_out is high exactly while state==LOCKED.
  - It rises on the edge that samples the LOCK_COUNT-th consecutive in-sequence word.
  - It falls on the edge that samples the UNLOCK_ERRORS-th consecutive mismatch.
- error_out is high for exactly one cycle per mismatching valid word. Back-to-back mismatches give back-to-back pulses.
- Reset value of every output is 0: locked_out=0, error_out=0, err_count_out=0. State resets to SEARCH, and expected, match_cnt and miss_cnt reset to 0.
- Asserting rst_n_in mid-lock clears all outputs immediately, with no clock needed. After release, the checker must reacquire through SEARCH→VERIFY.
- Throughput: one word per cycle with no bubbles required. valid_in may toggle arbitrarily.

## Test plan
- Lock acquisition, default params: valid words 1,2,4,8 on consecutive cycles → locked_out rises one cycle after word 8 is sampled; err_count_out=0; error_out never pulses.
- Single injected error: after lock, feed 3,6,0 (expected C),B,5 → exactly one error_out pulse, in the cycle after the 0; err_count_out=1; locked_out stays 1; B and 5 match because of the flywheel.
- Loss of lock: after lock, feed three consecutive wrong words (F,F,F) → three error_out pulses, err_count_out=3, locked_out falls with the third. Then 5,A,7,E → relock, and err_count_out stays 3.
- Search robustness: feed 0,0,1,2,7 (break),E,F,D → no lock until D is sampled (7 reseeds, then E,F,D give count 4), and err_count_out=0 throughout.
- Valid gaps and saturation: ERR_CNT_WIDTH=2, and words separated by 1–3 idle cycles → gaps do not age expected, lock still acquired. Five injected errors interleaved with matches → err_count_out stops at 3.
- Reset and clear: assert rst_n_in low asynchronously while locked → outputs read 0 before the next edge. clear_in together with valid_in and a mismatching word → no error_out pulse, err_count_out=0, state SEARCH.
